// File: rtl/ppu_vec.sv
// ppu_vec: LANES-wide scale / rounding-shift / bias / saturate pipeline with tile argmax.
// Build option: define RELU_EN to clamp saturated lanes to >= 0 (tile max uses clamped values).
module ppu_vec #(
    parameter int LANES   = 16,
    parameter int ACC_W   = 24,
    parameter int SCALE_W = 8,
    parameter int BIAS_W  = 8,
    parameter int SHIFT   = 4,
    parameter int OUT_W   = 8,
    parameter int BEAT_W  = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic                       in_last,
    input  logic [LANES*ACC_W-1:0]     partial_sum,
    input  logic [SCALE_W-1:0]         scale,
    input  logic [BIAS_W-1:0]          bias,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [LANES*OUT_W-1:0]     out_data,
    output logic                       out_last,
    output logic                       max_valid,
    output logic [OUT_W-1:0]           max_val,
    output logic [$clog2(LANES)-1:0]   max_lane,
    output logic [BEAT_W-1:0]          max_beat
);

    localparam int LW     = $clog2(LANES);
    localparam int PROD_W = ACC_W + SCALE_W + 1;
    // Two guard bits: one for the rounding add, one for the bias add.
    localparam int S_W    = PROD_W + 2;
    localparam int RND_SH = (SHIFT > 0) ? SHIFT - 1 : 0;
    localparam logic signed [S_W-1:0] RND = (SHIFT > 0) ? (S_W'(1) << RND_SH) : S_W'(0);
    localparam logic signed [OUT_W-1:0] OUT_MAX = {1'b0, {(OUT_W-1){1'b1}}};
    localparam logic signed [OUT_W-1:0] OUT_MIN = {1'b1, {(OUT_W-1){1'b0}}};

    typedef enum logic [0:0] {StIdle, StAccum} state_e;

    logic                     adv;
    logic                     v1_q, v2_q, v3_q;
    logic                     last1_q, last2_q, last3_q;
    logic [LANES*PROD_W-1:0]  prod_q, prod_d;
    logic [BIAS_W-1:0]        bias1_q;
    logic [LANES*S_W-1:0]     s_q, s_d;
    logic [LANES*OUT_W-1:0]   data_q, data_d;

    assign adv       = out_ready || !v3_q;
    assign in_ready  = adv;
    assign out_valid = v3_q;
    assign out_last  = last3_q;
    assign out_data  = data_q;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        logic signed [ACC_W-1:0]  ps;
        logic signed [PROD_W-1:0] ps_x, sc_x, p;
        logic signed [BIAS_W-1:0] bias_s;
        logic signed [S_W-1:0]    rsum, r, sv;
        logic signed [OUT_W-1:0]  sat;

        assign ps   = partial_sum[i*ACC_W +: ACC_W];
        assign ps_x = PROD_W'(ps);
        assign sc_x = PROD_W'({1'b0, scale});
        assign prod_d[i*PROD_W +: PROD_W] = ps_x * sc_x;

        assign p      = prod_q[i*PROD_W +: PROD_W];
        assign bias_s = bias1_q;
        assign rsum   = S_W'(p) + RND;
        assign r      = rsum >>> SHIFT;
        assign s_d[i*S_W +: S_W] = r + S_W'(bias_s);

        assign sv  = s_q[i*S_W +: S_W];
        assign sat = (sv > S_W'(OUT_MAX)) ? OUT_MAX :
                     (sv < S_W'(OUT_MIN)) ? OUT_MIN : sv[OUT_W-1:0];
`ifdef RELU_EN
        assign data_d[i*OUT_W +: OUT_W] = sat[OUT_W-1] ? '0 : sat;
`else
        assign data_d[i*OUT_W +: OUT_W] = sat;
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1_q    <= 1'b0;
            v2_q    <= 1'b0;
            v3_q    <= 1'b0;
            last1_q <= 1'b0;
            last2_q <= 1'b0;
            last3_q <= 1'b0;
            prod_q  <= '0;
            bias1_q <= '0;
            s_q     <= '0;
            data_q  <= '0;
        end else if (adv) begin
            v1_q    <= in_valid;
            last1_q <= in_last;
            prod_q  <= prod_d;
            bias1_q <= bias;
            v2_q    <= v1_q;
            last2_q <= last1_q;
            s_q     <= s_d;
            v3_q    <= v2_q;
            last3_q <= last2_q;
            data_q  <= data_d;
        end
    end

    // Pairwise max tree over the output beat; on ties the left (lower) lane wins.
    logic signed [OUT_W-1:0] bm_val;
    logic [LW-1:0]           bm_lane;

    always_comb begin
        logic signed [OUT_W-1:0] tv [LANES];
        logic [LW-1:0]           ti [LANES];
        for (int k = 0; k < LANES; k++) begin
            tv[k] = data_q[k*OUT_W +: OUT_W];
            ti[k] = LW'(k);
        end
        for (int l = 0; l < LW; l++) begin
            for (int j = 0; j < (LANES >> (l + 1)); j++) begin
                if (tv[2*j+1] > tv[2*j]) begin
                    tv[j] = tv[2*j+1];
                    ti[j] = ti[2*j+1];
                end else begin
                    tv[j] = tv[2*j];
                    ti[j] = ti[2*j];
                end
            end
        end
        bm_val  = tv[0];
        bm_lane = ti[0];
    end

    state_e                  state_q, state_d;
    logic                    hs, tile_done, take;
    logic signed [OUT_W-1:0] run_val_q, base_val, cmp_val;
    logic [LW-1:0]           run_lane_q, base_lane, cmp_lane;
    logic [BEAT_W-1:0]       run_beat_q, base_beat, cmp_beat, beat_q;
    logic                    max_valid_q;
    logic [OUT_W-1:0]        max_val_q;
    logic [LW-1:0]           max_lane_q;
    logic [BEAT_W-1:0]       max_beat_q;

    always_comb begin
        state_d   = state_q;
        hs        = v3_q && out_ready;
        tile_done = hs && last3_q;
        base_val  = run_val_q;
        base_lane = run_lane_q;
        base_beat = run_beat_q;
        unique case (state_q)
            StIdle: begin
                base_val  = OUT_MIN;
                base_lane = '0;
                base_beat = '0;
                if (hs && !last3_q) state_d = StAccum;
            end
            StAccum: begin
                if (tile_done) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
        // Strict greater-than: an equal value in a later beat keeps the earlier position.
        take     = bm_val > base_val;
        cmp_val  = take ? bm_val  : base_val;
        cmp_lane = take ? bm_lane : base_lane;
        cmp_beat = take ? beat_q  : base_beat;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            run_val_q   <= OUT_MIN;
            run_lane_q  <= '0;
            run_beat_q  <= '0;
            beat_q      <= '0;
            max_valid_q <= 1'b0;
            max_val_q   <= '0;
            max_lane_q  <= '0;
            max_beat_q  <= '0;
        end else begin
            state_q     <= state_d;
            max_valid_q <= tile_done;
            if (tile_done) begin
                max_val_q  <= cmp_val;
                max_lane_q <= cmp_lane;
                max_beat_q <= cmp_beat;
                run_val_q  <= OUT_MIN;
                run_lane_q <= '0;
                run_beat_q <= '0;
                beat_q     <= '0;
            end else if (hs) begin
                run_val_q  <= cmp_val;
                run_lane_q <= cmp_lane;
                run_beat_q <= cmp_beat;
                beat_q     <= beat_q + BEAT_W'(1);
            end
        end
    end

    assign max_valid = max_valid_q;
    assign max_val   = max_val_q;
    assign max_lane  = max_lane_q;
    assign max_beat  = max_beat_q;

endmodule

// File: tb/tb_ppu_vec.sv
// Randomised and directed bench for ppu_vec: scoreboard of per-lane arithmetic plus tile argmax model.
module tb_ppu_vec;

    localparam int LANES = 16;
    localparam int ACC_W = 24;
    localparam int SHIFT = 4;
    localparam int OUT_W = 8;
    localparam int PS_W  = LANES * ACC_W;
    localparam int OD_W  = LANES * OUT_W;
`ifdef RELU_EN
    localparam logic [7:0] EXP_NEG99  = 8'h00;
    localparam logic [7:0] EXP_NEG128 = 8'h00;
    localparam logic [7:0] EXP_NEG5   = 8'h00;
`else
    localparam logic [7:0] EXP_NEG99  = 8'h9D;
    localparam logic [7:0] EXP_NEG128 = 8'h80;
    localparam logic [7:0] EXP_NEG5   = 8'hFB;
`endif

    typedef struct {
        logic [PS_W-1:0] ps;
        logic [7:0]      sc;
        logic [7:0]      bi;
        bit              last;
    } beat_t;

    typedef struct {
        logic [7:0] val;
        logic [3:0] lane;
        logic [7:0] beat;
    } max_t;

    logic            clk, rst;
    logic            in_valid, in_ready, in_last;
    logic [PS_W-1:0] partial_sum;
    logic [7:0]      scale, bias;
    logic            out_valid, out_ready, out_last;
    logic [OD_W-1:0] out_data;
    logic            max_valid;
    logic [7:0]      max_val;
    logic [3:0]      max_lane;
    logic [7:0]      max_beat;

    ppu_vec #(
        .LANES(LANES), .ACC_W(ACC_W), .SCALE_W(8), .BIAS_W(8),
        .SHIFT(SHIFT), .OUT_W(OUT_W), .BEAT_W(8)
    ) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
        .partial_sum(partial_sum), .scale(scale), .bias(bias),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
        .max_valid(max_valid), .max_val(max_val), .max_lane(max_lane), .max_beat(max_beat)
    );

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int out_mode = 0;
    int gap_pct = 0;
    int n_acc = 0, n_out = 0, n_max = 0;
    int last_lat = 0, max_lat = 0, out_last_cyc = 0;
    bit in_hs = 0;
    logic [OD_W-1:0] last_out_data;
    logic            last_out_last;
    logic [7:0]      last_max_val, last_max_beat;
    logic [3:0]      last_max_lane;

    beat_t           stim_q[$];
    logic [OD_W-1:0] exp_q[$];
    bit              expl_q[$];
    int              acc_q[$];
    logic [OD_W-1:0] tile_q[$];
    max_t            mq[$];

    task automatic check(string tag, logic [127:0] got, logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] ref_lane(logic signed [23:0] ps, logic [7:0] sc,
                                            logic signed [7:0] bi);
        longint p, s;
        p = longint'(ps) * longint'(sc);
        if (SHIFT > 0) s = (p + (longint'(1) <<< (SHIFT - 1))) >>> SHIFT;
        else s = p;
        s = s + longint'(bi);
        if (s > 127) s = 127;
        if (s < -128) s = -128;
`ifdef RELU_EN
        if (s < 0) s = 0;
`endif
        return s[7:0];
    endfunction

    function automatic logic [OD_W-1:0] ref_beat(logic [PS_W-1:0] ps, logic [7:0] sc,
                                                 logic [7:0] bi);
        logic [OD_W-1:0] r;
        for (int l = 0; l < LANES; l++) r[l*8 +: 8] = ref_lane(ps[l*24 +: 24], sc, bi);
        return r;
    endfunction

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        out_ready = 0;
        forever begin
            @(posedge clk);
            #1;
            case (out_mode)
                0: out_ready = 1;
                1: out_ready = ($urandom_range(99) < 70);
                default: out_ready = 0;
            endcase
        end
    end

    // Driver: holds a beat until it is accepted, optional idle gaps between beats.
    initial begin
        bit offering;
        in_valid = 0; in_last = 0; partial_sum = '0; scale = '0; bias = '0;
        forever begin
            @(posedge clk);
            #1;
            if (rst) begin
                in_valid = 0;
            end else begin
                offering = in_valid && !in_hs;
                if (in_hs && stim_q.size() > 0) stim_q.delete(0);
                if (!offering) begin
                    if (stim_q.size() > 0 && $urandom_range(99) >= gap_pct) begin
                        partial_sum = stim_q[0].ps;
                        scale       = stim_q[0].sc;
                        bias        = stim_q[0].bi;
                        in_last     = stim_q[0].last;
                        in_valid    = 1;
                    end else begin
                        in_valid = 0;
                    end
                end
            end
        end
    end

    // Monitor / scoreboard, sampled mid-cycle.
    initial begin
        max_t            m;
        logic [OD_W-1:0] e, vv;
        bit              el;
        int              best, bl, bb;
        logic signed [7:0] lv;
        forever begin
            @(negedge clk);
            if (rst) begin
                in_hs = 0;
            end else begin
                if (max_valid) begin
                    n_max++;
                    max_lat = cyc - out_last_cyc;
                    last_max_val = max_val; last_max_lane = max_lane; last_max_beat = max_beat;
                    if (mq.size() == 0) begin
                        check("max_unexpected", max_valid, 0);
                    end else begin
                        m = mq.pop_front();
                        check("max_val", max_val, m.val);
                        check("max_lane", max_lane, m.lane);
                        check("max_beat", max_beat, m.beat);
                    end
                end
                in_hs = in_valid && in_ready;
                if (in_hs) begin
                    exp_q.push_back(ref_beat(partial_sum, scale, bias));
                    expl_q.push_back(in_last);
                    acc_q.push_back(cyc);
                    n_acc++;
                end
                if (out_valid && out_ready) begin
                    n_out++;
                    if (exp_q.size() == 0) begin
                        check("out_unexpected", out_valid, 0);
                    end else begin
                        e = exp_q.pop_front();
                        el = expl_q.pop_front();
                        last_lat = cyc - acc_q.pop_front();
                        check("out_data", out_data, e);
                        check("out_last", out_last, el);
                        last_out_data = out_data;
                        last_out_last = out_last;
                        tile_q.push_back(e);
                        if (el) begin
                            best = -128; bl = 0; bb = 0;
                            for (int b = 0; b < tile_q.size(); b++) begin
                                vv = tile_q[b];
                                for (int l = 0; l < LANES; l++) begin
                                    lv = vv[l*8 +: 8];
                                    if (int'(lv) > best) begin
                                        best = lv; bl = l; bb = b % 256;
                                    end
                                end
                            end
                            m.val = best[7:0]; m.lane = bl[3:0]; m.beat = bb[7:0];
                            mq.push_back(m);
                            tile_q.delete();
                            out_last_cyc = cyc;
                        end
                    end
                end
            end
        end
    end

    task automatic push(logic [PS_W-1:0] ps, logic [7:0] sc, logic [7:0] bi, bit last);
        beat_t b;
        b.ps = ps; b.sc = sc; b.bi = bi; b.last = last;
        stim_q.push_back(b);
    endtask

    task automatic drain(int budget);
        int n = 0;
        while ((stim_q.size() > 0 || exp_q.size() > 0 || mq.size() > 0) && n < budget) begin
            @(posedge clk);
            n++;
        end
        repeat (3) @(posedge clk);
        check("drain_pending", stim_q.size() + exp_q.size() + mq.size(), 0);
    endtask

    task automatic wait_acc(int target, int budget);
        int n = 0;
        while (n_acc < target && n < budget) begin
            @(posedge clk);
            n++;
        end
        check("acc_wait", n_acc, target);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2;
        rst = 1;
        stim_q.delete(); exp_q.delete(); expl_q.delete(); acc_q.delete();
        tile_q.delete(); mq.delete();
        in_hs = 0;
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_max_valid", max_valid, 0);
        check("rst_out_data", out_data, 0);
        repeat (2) @(posedge clk);
        #2;
        rst = 0;
    endtask

    initial begin
        logic [PS_W-1:0] ps;
        int v, base, len;
        rst = 1;
        repeat (3) @(posedge clk);
        #2;
        check("reset_out_valid", out_valid, 0);
        check("reset_out_data", out_data, 0);
        check("reset_out_last", out_last, 0);
        check("reset_max_valid", max_valid, 0);
        check("reset_max_val", max_val, 0);
        check("reset_max_lane", max_lane, 0);
        check("reset_max_beat", max_beat, 0);
        check("reset_in_ready", in_ready, 1);
        rst = 0;

        // Identity
        for (int l = 0; l < LANES; l++) ps[l*24 +: 24] = 24'h20;
        push(ps, 8'd16, 8'd0, 1);
        drain(200);
        check("ident_data", last_out_data, {16{8'h20}});
        check("ident_last", last_out_last, 1);
        check("ident_latency", last_lat, 3);
        check("ident_max_latency", max_lat, 1);
        check("ident_max_val", last_max_val, 8'd32);
        check("ident_max_lane", last_max_lane, 0);
        check("ident_max_beat", last_max_beat, 0);

        // Rounding and bias
        ps = '0; ps[23:0] = 24'd16;
        push(ps, 8'd16, 8'd1, 1);
        drain(200);
        check("round_pos", last_out_data[7:0], 8'h11);
        check("bias_only", last_out_data[15:8], 8'h01);
        ps = '0; ps[23:0] = 24'hFFFF9C;
        push(ps, 8'd16, 8'd1, 1);
        drain(200);
        check("round_neg", last_out_data[7:0], EXP_NEG99);

        // Saturation
        ps = '0; ps[23:0] = 24'h7FFFFF; ps[47:24] = 24'h800000;
        push(ps, 8'd255, 8'd0, 1);
        drain(200);
        check("sat_pos", last_out_data[7:0], 8'h7F);
        check("sat_neg", last_out_data[15:8], EXP_NEG128);

        // Multi-beat argmax with ties
        base = n_max;
        ps = '0; ps[3*24 +: 24] = 24'd50;
        push(ps, 8'd16, 8'd0, 0);
        ps = '0; ps[7*24 +: 24] = 24'd90; ps[9*24 +: 24] = 24'd90;
        push(ps, 8'd16, 8'd0, 0);
        ps = '0; ps[1*24 +: 24] = 24'd90;
        push(ps, 8'd16, 8'd0, 1);
        drain(200);
        check("argmax_val", last_max_val, 8'd90);
        check("argmax_lane", last_max_lane, 7);
        check("argmax_beat", last_max_beat, 1);
        check("argmax_pulses", n_max - base, 1);

        // Backpressure
        @(posedge clk);
        #2;
        out_mode = 2; out_ready = 0;
        base = n_acc;
        v = n_out;
        for (int b = 0; b < 5; b++) begin
            for (int l = 0; l < LANES; l++) ps[l*24 +: 24] = 24'(b * 20 + l);
            push(ps, 8'd16, 8'd0, b == 4);
        end
        repeat (6) @(posedge clk);
        @(negedge clk);
        check("bp_accepted", n_acc - base, 3);
        check("bp_in_ready", in_ready, 0);
        out_mode = 0;
        drain(300);
        check("bp_emerged", n_out - v, 5);

        // Reset mid-tile
        out_mode = 2;
        base = n_acc;
        for (int b = 0; b < 2; b++) begin
            for (int l = 0; l < LANES; l++) ps[l*24 +: 24] = 24'(100 + l);
            push(ps, 8'd16, 8'd0, 0);
        end
        wait_acc(base + 2, 50);
        do_reset();
        base = n_max;
        out_mode = 0;
        repeat (4) @(posedge clk);
        check("rst_no_max", n_max - base, 0);
        for (int l = 0; l < LANES; l++) ps[l*24 +: 24] = -24'sd5;
        push(ps, 8'd16, 8'd0, 1);
        drain(200);
        check("post_rst_max_val", last_max_val, EXP_NEG5);
        check("post_rst_max_lane", last_max_lane, 0);
        check("post_rst_max_beat", last_max_beat, 0);
        check("post_rst_pulses", n_max - base, 1);

        // Beat counter wrap: 258-beat tile, max placed on beat 257
        for (int b = 0; b < 258; b++) begin
            for (int l = 0; l < LANES; l++) begin
                v = int'($urandom_range(100)) - 50;
                ps[l*24 +: 24] = 24'(v);
            end
            if (b == 257) ps[5*24 +: 24] = 24'd100;
            push(ps, 8'd16, 8'd0, b == 257);
        end
        drain(2000);
        check("wrap_max_val", last_max_val, 8'd100);
        check("wrap_max_lane", last_max_lane, 5);
        check("wrap_max_beat", last_max_beat, 1);

        // Random tiles with random backpressure and input gaps
        out_mode = 1;
        gap_pct = 20;
        for (int t = 0; t < 40; t++) begin
            len = $urandom_range(6, 1);
            for (int b = 0; b < len; b++) begin
                for (int l = 0; l < LANES; l++) begin
                    case ($urandom_range(3))
                        0: v = int'($urandom);
                        1: v = int'($urandom_range(6000)) - 3000;
                        default: v = int'($urandom_range(400)) - 200;
                    endcase
                    ps[l*24 +: 24] = 24'(v);
                end
                push(ps, 8'($urandom), 8'($urandom), b == len - 1);
            end
        end
        drain(20000);
        check("final_tile_empty", tile_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/ppu_vec.md
Name: ppu_vec

Overview:
Parametrised post-processing unit; successor to the fixed 16-lane PPU. Sits between the systolic-array accumulator drain and the output buffer. Each beat it takes LANES signed partial sums and applies per-beat scale, rounding shift, bias and saturation. It also tracks a running maximum and its lane/beat position across a multi-beat tile. Unlike the fixed PPU it adds valid/ready flow control on both sides, tile framing and argmax.

Parameters:
LANES, 16, number of partial-sum lanes per beat (power of 2, >=2)
ACC_W, 24, signed partial-sum width per lane
SCALE_W, 8, unsigned scale width
BIAS_W, 8, signed bias width
SHIFT, 4, right-shift amount after scaling (0..ACC_W)
OUT_W, 8, signed output width per lane
BEAT_W, 8, width of beat counter within a tile

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-high
in_valid  in  1  input beat valid
in_ready  out  1  input beat accepted when in_valid && in_ready
in_last  in  1  marks final beat of a tile
partial_sum  in  LANES*ACC_W  lane i at bits [i*ACC_W +: ACC_W], signed
scale  in  SCALE_W  unsigned, sampled with the beat
bias  in  BIAS_W  signed, sampled with the beat
out_valid  out  1  output beat valid
out_ready  in  1  downstream ready
out_data  out  LANES*OUT_W  lane i at [i*OUT_W +: OUT_W], signed
out_last  out  1  in_last carried with the beat
max_valid  out  1  one-cycle pulse: tile max result valid
max_val  out  OUT_W  signed tile maximum of post-processed values
max_lane  out  clog2(LANES)  lane of max_val
max_beat  out  BEAT_W  beat index of max_val within tile

Behaviour:
- Reset: all outputs 0; pipeline valids cleared; running max = -2^(OUT_W-1); beat counter 0; FSM IDLE.
- Pipeline: 3 stages, global advance adv = out_ready || !out_valid. in_ready = adv. Latency 3 cycles from accept to out_valid when no stall. Order preserved; stalled stages hold data.
- S1: prod = partial_sum_i (signed) * {1'b0,scale}; width ACC_W+SCALE_W+1.
- S2: if SHIFT>0, r = (prod + 2^(SHIFT-1)) >>> SHIFT (arithmetic; round half up), else r = prod. Then s = r + sign-extended bias. Internal widths must never overflow.
- S3: saturate s to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
- Max: evaluated on the S3 beat at output handshake (out_valid && out_ready).
  - Beat max comes from a reduction tree; ties go to the lowest lane.
  - Compare against the running max with strict greater-than, so ties keep the earlier beat.
- FSM:
  - IDLE: enters ACCUM on the first handshaken beat with out_last=0. A handshaken beat with out_last=1 (single-beat tile) pulses max_valid directly and stays IDLE.
  - ACCUM: updates the running max and beat counter on each handshake.
  - On a handshake with out_last=1: max_val/max_lane/max_beat take the final compare result; max_valid=1 for exactly one cycle; running max reinitialises; beat counter returns to 0; FSM goes to IDLE.
- max_val/max_lane/max_beat hold until the next tile completes.
- Beat counter wraps modulo 2^BEAT_W; no error is flagged.
- rst asserted mid-tile: everything returns to reset values immediately; partial tile discarded; no max_valid.

Optional Feature:
RELU_EN:
- Defined: after saturation each lane is clamped to max(value, 0); the tile max uses the clamped values, so max_val >= 0.
- Undefined: signed saturated values pass unchanged.

Test Plan:
- Identity: SHIFT=4, scale=16, bias=0, every lane 0x000020, in_last=1, out_ready=1 -> after 3 cycles out_data every lane 8'h20, out_last=1; next cycle max_valid=1, max_val=32, max_lane=0, max_beat=0.
- Rounding/bias: lane0=16, scale=16, bias=1 -> lane0 out=17; lane0=-100 (24'hFFFF9C), scale=16, bias=1 -> -99 (8'h9D), or 0 with RELU_EN.
- Saturation: lane0=24'h7FFFFF, scale=255 -> 127 (8'h7F); lane1=24'h800000, scale=255 -> -128 (8'h80), or 0 with RELU_EN.
- Multi-beat argmax: identity settings, 3-beat tile:
  - beat0 lane3=50;
  - beat1 lane7=90 and lane9=90;
  - beat2 lane1=90;
  - all other lanes 0.
  - -> max_val=90, max_lane=7, max_beat=1; max_valid pulses once, after the beat2 handshake.
- Backpressure: out_ready=0 for 6 cycles while 5 beats offered -> exactly 3 accepted, in_ready=0 thereafter. On release, all 5 beats emerge in order with no loss or duplication.
- Reset mid-tile: 2 beats of a 4-beat tile accepted, rst pulsed -> out_valid=0, max_valid never asserts. A following 1-beat tile with all lanes -5 -> max_val=-5, max_beat=0.
